sa_result_writeback: RTL

//  Drains one NxN signed accumulator matrix from the systolic array to result BRAM.

---
 rtl/sa_result_writeback_if.sv | 32 +++
 rtl/sa_result_writeback.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sa_result_writeback_if.sv
// Capture/drain handshake and BRAM write port of the systolic-array result writeback.
// The master drives the matrix and BRAM ready. The slave (the writeback block) drives the write port and status.
interface sa_result_writeback_if #(
    parameter int N      = 32,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int LANES  = 1,
    parameter int ADDR_W = $clog2(N * N / LANES),
    parameter int SAT_W  = $clog2(N * N + 1)
);
    logic                                   i_valid;
    logic signed [N-1:0][N-1:0][ACC_W-1:0]  i_matrix;
    logic [4:0]                             i_shift;
    logic                                   i_wr_ready;
    logic                                   o_busy;
    logic                                   o_wr_en;
    logic [ADDR_W-1:0]                      o_wr_addr;
    logic [LANES*OUT_W-1:0]                 o_wr_data;
    logic                                   o_done;
    logic                                   o_drop;
    logic [SAT_W-1:0]                       o_sat_count;

    modport master (
        output i_valid, i_matrix, i_shift, i_wr_ready,
        input  o_busy, o_wr_en, o_wr_addr, o_wr_data, o_done, o_drop, o_sat_count
    );

    modport slave (
        input  i_valid, i_matrix, i_shift, i_wr_ready,
        output o_busy, o_wr_en, o_wr_addr, o_wr_data, o_done, o_drop, o_sat_count
    );
endinterface

// File: rtl/sa_result_writeback.sv
// Drains one captured NxN accumulator matrix to BRAM in row-major order.
// Each element is shifted (optionally rounded), saturated to OUT_W, and packed LANES per word.
module sa_result_writeback #(
    parameter int N         = 32,
    parameter int ACC_W     = 32,
    parameter int OUT_W     = 16,
    parameter int LANES     = 1,
    parameter int ADDR_W    = $clog2(N * N / LANES),
    parameter int BASE_ADDR = 0,
    parameter int ROUND     = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    sa_result_writeback_if.slave  bus
);
    localparam int WORDS = N * N / LANES;
    localparam int EW    = $clog2(N * N);
    localparam int SAT_W = $clog2(N * N + 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);
    localparam logic signed [ACC_W:0] MAX_V = $signed({{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

    generate
        if ((N * N) % LANES != 0) begin : g_lanes_check
            $error("sa_result_writeback: N*N must be a multiple of LANES");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t                  state;
    logic [ADDR_W-1:0]       idx;
    logic [ADDR_W-1:0]       nidx;
    logic [4:0]              shift_q;
    logic [4:0]              shift_in;
    logic signed [ACC_W-1:0] mat_q [N*N];
    logic [N*N*ACC_W-1:0]    in_flat;
    logic [LANES*OUT_W-1:0]  nxt_data;
    logic [LANES-1:0]        lane_sat;
    logic [SAT_W-1:0]        nxt_sat;
    logic [SAT_W-1:0]        word_sat_q;
    logic                    busy_q, wr_en_q, done_q, drop_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [LANES*OUT_W-1:0]  data_q;
    logic [SAT_W-1:0]        sat_q;
    logic                    capture;
    logic                    fire;

    // Widened by one bit so the half-LSB rounding add cannot overflow.
    function automatic logic [OUT_W:0] scale(input logic signed [ACC_W-1:0] x, input logic [4:0] s);
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] rnd;
        ext = {x[ACC_W-1], x};
        rnd = '0;
        if (ROUND != 0 && s != 5'd0) rnd = (ACC_W+1)'(1) << (s - 5'd1);
        ext = (ext + rnd) >>> s;
        if (ext > MAX_V)      return {1'b1, MAX_V[OUT_W-1:0]};
        else if (ext < MIN_V) return {1'b1, MIN_V[OUT_W-1:0]};
        else                  return {1'b0, ext[OUT_W-1:0]};
    endfunction

    assign in_flat  = bus.i_matrix;
    assign capture  = (state == IDLE) && bus.i_valid;
    assign fire     = wr_en_q && bus.i_wr_ready;
    assign shift_in = (int'(bus.i_shift) >= ACC_W) ? 5'(ACC_W - 1) : bus.i_shift;
    assign nidx     = (state == IDLE || idx == LAST) ? '0 : idx + 1'b1;
    assign nxt_sat  = SAT_W'($countones(lane_sat));

    // Word 0 is built straight from the input bus at capture; later words come from the captured copy.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [EW-1:0]           elem;
        logic signed [ACC_W-1:0] x;
        logic [4:0]              s;
        // NOTE: every always_comb output is given a default first, so no path can infer a latch.
        always_comb begin
            elem = EW'(nidx) * EW'(LANES) + EW'(k);
            x    = mat_q[elem];
            s    = shift_q;
            if (state == IDLE) begin
                x = in_flat[k*ACC_W +: ACC_W];
                s = shift_in;
            end
        end
        assign {lane_sat[k], nxt_data[k*OUT_W +: OUT_W]} = scale(x, s);
    end

    // NOTE: the captured matrix has no reset; it is only read after a capture has overwritten it.
    for (genvar e = 0; e < N * N; e++) begin : g_cap
        always_ff @(posedge i_clk) begin
            if (capture) mat_q[e] <= in_flat[e*ACC_W +: ACC_W];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            idx        <= '0;
            shift_q    <= '0;
            word_sat_q <= '0;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
            addr_q     <= ADDR_W'(BASE_ADDR);
            data_q     <= '0;
            sat_q      <= '0;
        end else begin
            done_q <= 1'b0;
            drop_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        shift_q    <= shift_in;
                        idx        <= '0;
                        sat_q      <= '0;
                        addr_q     <= ADDR_W'(BASE_ADDR);
                        data_q     <= nxt_data;
                        word_sat_q <= nxt_sat;
                        busy_q     <= 1'b1;
                        wr_en_q    <= 1'b1;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    drop_q <= bus.i_valid;
                    if (fire) begin
                        sat_q <= sat_q + word_sat_q;
                        idx   <= nidx;
                        if (idx == LAST) begin
                            busy_q  <= 1'b0;
                            wr_en_q <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            addr_q     <= ADDR_W'(BASE_ADDR) + nidx;
                            data_q     <= nxt_data;
                            word_sat_q <= nxt_sat;
                        end
                    end
                end
                DONE: begin
                    drop_q <= bus.i_valid;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_busy      = busy_q;
    assign bus.o_wr_en     = wr_en_q;
    assign bus.o_wr_addr   = addr_q;
    assign bus.o_wr_data   = data_q;
    assign bus.o_done      = done_q;
    assign bus.o_drop      = drop_q;
    assign bus.o_sat_count = sat_q;
endmodule
